// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - four-way round-robin arbiter with done release and hold-limit timeout
module rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic             pick_found;
    logic [1:0]       pick_id;
    logic [1:0]       scan_idx;

    logic             owner_req;
    logic             at_limit;
    logic             release_now;
    logic             limit_only;

    // One-hot decode of a requester index.
    function automatic logic [3:0] onehot4(input logic [1:0] id);
        logic [3:0] v;
        v = 4'b0000;
        v[id] = 1'b1;
        return v;
    endfunction

    // First requesting index when scanning upward from the rotating pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = 2'd0;
        scan_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr + 2'(i);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    // Release causes for the current owner; the hold limit alone flags a timeout.
    always_comb begin
        owner_req   = req[grant_id];
        at_limit    = (hold_cnt == HOLD_LAST);
        release_now = done || !owner_req || at_limit;
        limit_only  = at_limit && !done && owner_req;
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            grant    <= 4'b0000;
            grant_id <= 2'd0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout  <= 1'b0;
                    hold_cnt <= '0;
                    if (pick_found) begin
                        state    <= ST_BUSY;
                        grant    <= onehot4(pick_id);
                        grant_id <= pick_id;
                        valid    <= 1'b1;
                    end else begin
                        grant    <= 4'b0000;
                        grant_id <= 2'd0;
                        valid    <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (release_now) begin
                        // Always drop to IDLE so consecutive grants are separated by a gap.
                        state    <= ST_IDLE;
                        ptr      <= grant_id + 2'd1;
                        hold_cnt <= '0;
                        grant    <= 4'b0000;
                        grant_id <= 2'd0;
                        valid    <= 1'b0;
                        timeout  <= limit_only;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                        timeout  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                    grant    <= 4'b0000;
                    grant_id <= 2'd0;
                    valid    <= 1'b0;
                    timeout  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - randomized and directed self-checking bench for rr_arbiter
module tb_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       valid;
    logic       timeout;

    int n_vec;
    int n_err;

    // reference model: owner index (-1 when idle), pointer, cycles held, timeout flag
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .valid    (valid),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input logic [3:0] q, input bit d);
        bit lim;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_to    = 0;
        end else if (m_owner < 0) begin
            m_to   = 0;
            m_hold = 0;
            for (int i = 0; i < 4; i++) begin
                int j;
                j = (m_ptr + i) % 4;
                if (m_owner < 0 && q[j]) m_owner = j;
            end
        end else begin
            lim = (m_hold == MAX_HOLD - 1);
            if (d || !q[m_owner] || lim) begin
                m_to    = lim && !d && q[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold++;
                m_to = 0;
            end
        end
    endtask

    task automatic step(input bit r, input logic [3:0] q, input bit d);
        logic [3:0] eg;
        @(negedge clk);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        model_update(r, q, d);
        #1;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("grant", 32'(grant), 32'(eg));
        check("grant_id", 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("valid", 32'(valid), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
        check("onehot", 32'($onehot0(grant)), 32'd1);
    endtask

    initial begin
        logic [3:0] seq27 [9];
        logic [3:0] rq;
        n_vec = 0;
        n_err = 0;
        m_owner = -1;
        m_ptr = 0;
        m_hold = 0;
        m_to = 0;
        rst = 1'b1;
        req = 4'b0000;
        done = 1'b0;

        // reset for two cycles
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);
        check("reset_grant", 32'(grant), 32'd0);

        // full rotation with done pulsed on every granted cycle
        seq27 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 9; i++) begin
            step(0, 4'b1111, m_owner >= 0);
            check("rot_seq", 32'(grant), 32'(seq27[i]));
        end

        // ptr = 1 after owner 0 releases; 1001 must pick requester 3
        step(0, 4'b1001, 1);
        step(0, 4'b1001, 0);
        check("ptr1_pick3", 32'(grant), 32'b1000);
        check("ptr1_id3", 32'(grant_id), 32'd3);
        step(0, 4'b0000, 0);

        // hold-limit timeout with a single persistent requester
        step(0, 4'b0010, 0);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            step(0, 4'b0010, 0);
            check("hold_grant", 32'(grant), 32'b0010);
        end
        step(0, 4'b0010, 0);
        check("to_release", 32'(grant), 32'd0);
        check("to_pulse", 32'(timeout), 32'd1);
        step(0, 4'b0010, 0);
        check("to_regrant", 32'(grant), 32'b0010);
        check("to_cleared", 32'(timeout), 32'd0);

        // done on the limit cycle is a normal release
        for (int i = 0; i < MAX_HOLD - 1; i++) step(0, 4'b0010, 0);
        step(0, 4'b0010, 1);
        check("limit_done_grant", 32'(grant), 32'd0);
        check("limit_done_to", 32'(timeout), 32'd0);

        // done while idle with no requests changes nothing
        step(0, 4'b0000, 1);
        step(0, 4'b0000, 1);
        check("idle_done", 32'(grant), 32'd0);

        // reset mid-grant, first grant after reset starts from requester 0
        step(1, 4'b0000, 0);
        step(0, 4'b0100, 0);
        check("mid_owner2", 32'(grant), 32'b0100);
        step(1, 4'b1111, 0);
        check("mid_rst", 32'(grant), 32'd0);
        step(0, 4'b1111, 0);
        check("post_rst", 32'(grant), 32'b0001);

        // owner 2 drops its request on its third cycle
        step(1, 4'b0000, 0);
        step(0, 4'b0100, 0);
        step(0, 4'b1111, 0);
        step(0, 4'b1111, 0);
        step(0, 4'b1011, 0);
        check("drop_grant", 32'(grant), 32'd0);
        check("drop_to", 32'(timeout), 32'd0);
        step(0, 4'b1011, 0);
        check("drop_next", 32'(grant), 32'b1000);

        // randomized traffic with sticky requests so hold limits are reached
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 2, rq, $urandom_range(0, 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum number of consecutive cycles one requester may hold the grant (legal range 2..15).
REQ-002 Parameter CNT_W, default 4: width of the hold counter; 2**CNT_W SHALL be >= MAX_HOLD.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  4  request lines; bit k high means requester k wants the shared resource.
REQ-006 done  input  1  one-cycle release pulse from the current owner; ignored when no grant is active.
REQ-007 grant  output  4  one-hot grant, registered; all-zero when idle.
REQ-008 grant_id  output  2  binary index of the granted requester; 0 when idle.
REQ-009 valid  output  1  high exactly when grant is non-zero.
REQ-010 timeout  output  1  one-cycle pulse marking a forced release by the hold counter.

Function
REQ-011 The block SHALL implement two states: IDLE and BUSY.
REQ-012 The block SHALL keep a 2-bit rotating priority pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE, req != 0 at edge t: at t+1, grant = one-hot of the first set bit in search order, grant_id = its index, valid = 1, hold_cnt = 0, state = BUSY (latency 1 cycle).
REQ-014 IDLE, req == 0: the block SHALL hold outputs at 0, keep ptr unchanged, and ignore done.
REQ-015 BUSY, owner k: a release SHALL occur when done = 1, or req[k] = 0, or hold_cnt == MAX_HOLD-1.
REQ-016 BUSY, no release: grant, grant_id and ptr SHALL hold; hold_cnt SHALL increment by 1.
REQ-017 Release at edge t: at t+1, grant = 0, grant_id = 0, valid = 0, ptr = (k+1) mod 4, hold_cnt = 0, state = IDLE.
REQ-018 There SHALL be a minimum of one idle cycle between consecutive grants (no back-to-back handover).
REQ-019 On release, timeout SHALL be 1 for exactly the following cycle only when the release cause is the hold counter alone (done = 0 and req[k] = 1).
REQ-020 Simultaneous done/req-drop and counter limit: the release SHALL count as normal, with timeout = 0.
REQ-021 Changes on req bits other than the owner's SHALL NOT affect BUSY behaviour.
REQ-022 hold_cnt SHALL never exceed MAX_HOLD-1 and SHALL NOT wrap.
REQ-023 grant SHALL be one-hot or zero in every cycle; valid SHALL equal |grant.

Reset
REQ-024 At any edge with rst = 1 (including mid-BUSY), the block SHALL set state = IDLE, ptr = 0, hold_cnt = 0, grant = 0, grant_id = 0, valid = 0, timeout = 0.
REQ-025 rst SHALL take precedence over req and done in the same cycle.
REQ-026 The first arbitration after reset SHALL use ptr = 0.

Verification
REQ-027 rst = 1 for 2 cycles, then req = 4'b1111 held, done pulsed on each granted cycle -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001; grant_id 0,1,2,3,0.
REQ-028 After owner 0 releases (ptr = 1), req = 4'b1001 -> next grant = 1000, grant_id = 3.
REQ-029 MAX_HOLD = 8, req = 4'b0010 held, done = 0 -> grant = 0010 for exactly 8 cycles, then 0000 with timeout = 1 for one cycle, then grant = 0010 again on the following cycle.
REQ-030 Owner 2 granted, req[2] drops to 0 on cycle 3 of the grant while req = 4'b1011 otherwise -> grant = 0000 next cycle with timeout = 0, then grant = 1000 (ptr = 3).
REQ-031 rst = 1 while grant = 0100 with req = 4'b1111 -> grant = 0000 at the next edge; after rst falls, first grant = 0001.
REQ-032 done = 1 on the same cycle hold_cnt reaches MAX_HOLD-1 -> release with timeout = 0; done pulsed in IDLE with req = 0 -> no output change.
